// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table and nibble width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

    localparam int NIB_W = 4;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Active-low gfedcba patterns, indexed by hex value 0..F.
    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_glyph_lut.sv
// Nibble to active-low 7-segment glyph lookup.
// Latency: combinational.
// Backpressure: none.
module seg7_glyph_lut
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [6:0]       seg
);

    // Straight table lookup; every 4-bit code has a glyph.
    always_comb begin
        seg = GLYPH_TBL[nib];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned data update.
// Latency: all outputs registered, one cycle behind the scan position.
// Backpressure: none; LOAD is always accepted, the display free-runs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NIB_W*NUM_DIGITS-1:0] VALUE,
    input  logic                        LOAD,
    input  logic [NUM_DIGITS-1:0]       DP_IN,
    input  logic [NUM_DIGITS-1:0]       DIGIT_EN,
    input  logic                        LZ_BLANK,
    output logic [6:0]                  SEG,
    output logic                        DP,
    output logic [NUM_DIGITS-1:0]       AN,
    output logic                        FRAME_DONE
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             boundary;

    // Shadow (written any time) and display (changes only at frame boundary)
    logic [NIB_W*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]       sh_dp_q,  sh_dp_d;
    logic [NUM_DIGITS-1:0]       sh_en_q,  sh_en_d;
    logic                        pend_q,   pend_d;
    logic [NIB_W*NUM_DIGITS-1:0] ds_val_q, ds_val_d;
    logic [NUM_DIGITS-1:0]       ds_dp_q,  ds_dp_d;
    logic [NUM_DIGITS-1:0]       ds_en_q,  ds_en_d;

    // Registered pin drivers
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q,  dp_d;
    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic                  fd_q,  fd_d;

    logic [NIB_W-1:0]      nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_above;
    logic [NUM_DIGITS-1:0] suppress;
    logic [6:0]            glyph;

    // Slot counter and digit index advance; flag the last cycle of the frame.
    always_comb begin
        boundary = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Shadow capture on LOAD; display swaps only on the frame boundary so a frame never tears.
    always_comb begin
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_en_d  = sh_en_q;
        pend_d   = pend_q;
        ds_val_d = ds_val_q;
        ds_dp_d  = ds_dp_q;
        ds_en_d  = ds_en_q;
        if (LOAD) begin
            sh_val_d = VALUE;
            sh_dp_d  = DP_IN;
            sh_en_d  = DIGIT_EN;
            pend_d   = 1'b1;
        end
        if (boundary) begin
            if (LOAD) begin
                // Same-cycle load bypasses the shadow so it costs no extra frame.
                ds_val_d = VALUE;
                ds_dp_d  = DP_IN;
                ds_en_d  = DIGIT_EN;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                ds_val_d = sh_val_q;
                ds_dp_d  = sh_dp_q;
                ds_en_d  = sh_en_q;
                pend_d   = 1'b0;
            end
        end
    end

    // Leading-zero detection from the top digit down, then per-digit suppression.
    always_comb begin
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            nib[i] = ds_val_q[i*NIB_W +: NIB_W];
        end
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            acc           = acc & (nib[i] == '0);
            zero_above[i] = acc;
        end
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            // Digit 0 is exempt so an all-zero value still reads "0".
            suppress[i] = !ds_en_q[i] || (LZ_BLANK && (i != 0) && zero_above[i]);
        end
    end

    seg7_glyph_lut u_glyph (
        .nib (nib[idx_q]),
        .seg (glyph)
    );

    // Next pin values: dark during the ghost-blanking window or for a suppressed digit.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        fd_d  = boundary;
        if (!((32'(cnt_q) < BLANK_CYCLES) || suppress[idx_q])) begin
            an_d[idx_q] = 1'b0;
            seg_d       = glyph;
            dp_d        = ~ds_dp_q[idx_q];
        end
    end

    // All state; reset darkens the pins at once and restarts the scan at digit 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            pend_q   <= 1'b0;
            ds_val_q <= '0;
            ds_dp_q  <= '0;
            ds_en_q  <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            an_q     <= '1;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_en_q  <= sh_en_d;
            pend_q   <= pend_d;
            ds_val_q <= ds_val_d;
            ds_dp_q  <= ds_dp_d;
            ds_en_q  <= ds_en_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign AN         = an_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
// A frame is 16 cycles; the edge that raises FRAME_DONE is followed by edges
// sampling scan states 0..15 (slot = st/4, position in slot = st%4).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Expected lit appearance of each slot (cycle 0 of every slot is always dark).
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .VALUE      (value),
        .LOAD       (load),
        .DP_IN      (dp_in),
        .DIGIT_EN   (digit_en),
        .LZ_BLANK   (lz_blank),
        .SEG        (seg),
        .DP         (dp),
        .AN         (an),
        .FRAME_DONE (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [3:0] a, input logic [6:0] g, input logic d);
        exp_an[s]  = a;
        exp_seg[s] = g;
        exp_dp[s]  = d;
    endtask

    // Advance one edge per state and compare pins against the expected slot table.
    task automatic scan_check(input string tag, input int first, input int last);
        for (int st = first; st <= last; st++) begin
            int s;
            s = st / 4;
            tick();
            if (st % 4 == 0) begin
                chk($sformatf("%s_an%0d", tag, st), 16'(an), 16'hF);
                chk($sformatf("%s_seg%0d", tag, st), 16'(seg), 16'h7F);
                chk($sformatf("%s_dp%0d", tag, st), 16'(dp), 16'h1);
            end else begin
                chk($sformatf("%s_an%0d", tag, st), 16'(an), 16'(exp_an[s]));
                chk($sformatf("%s_seg%0d", tag, st), 16'(seg), 16'(exp_seg[s]));
                chk($sformatf("%s_dp%0d", tag, st), 16'(dp), 16'(exp_dp[s]));
            end
            chk($sformatf("%s_fd%0d", tag, st), 16'(frame_done), (st == 15) ? 16'h1 : 16'h0);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value    = v;
        dp_in    = d;
        digit_en = e;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        while (!frame_done && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 16'(frame_done), 16'h1);
    endtask

    initial begin
        int first_fd;
        logic [3:0] first_an;

        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            value    = 16'($urandom);
            load     = 1'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            lz_blank = 1'($urandom);
            tick();
        end
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_fd", 16'(frame_done), 16'h0);

        // Release; display enables cleared by reset, so nothing lights before a load.
        load  = 1'b0;
        rst_n = 1'b1;
        first_fd = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (frame_done && first_fd == 0) first_fd = k;
            chk($sformatf("post_rst_an%0d", k), 16'(an), 16'hF);
        end
        chk("post_rst_fd_at", 16'(first_fd), 16'd16);

        // ---------------- LZ blanking on ----------------
        lz_blank = 1'b1;
        do_load(16'h00A5, 4'b0010, 4'hF);
        wait_fd("lz_on_fd");
        set_slot(0, 4'hE, 7'h12, 1'b1);
        set_slot(1, 4'hD, 7'h08, 1'b0);
        set_slot(2, 4'hF, 7'h7F, 1'b1);
        set_slot(3, 4'hF, 7'h7F, 1'b1);
        scan_check("lz_on", 0, 15);

        // ---------------- LZ blanking off (level input, no reload needed) ----------------
        lz_blank = 1'b0;
        set_slot(2, 4'hB, 7'h40, 1'b1);
        set_slot(3, 4'h7, 7'h40, 1'b1);
        scan_check("lz_off", 0, 15);

        // ---------------- tear-free: load during slot 1 ----------------
        scan_check("tear_pre", 0, 4);
        value = 16'h1234;
        load  = 1'b1;
        scan_check("tear_ld", 5, 5);
        load  = 1'b0;
        scan_check("tear_old", 6, 15);
        set_slot(0, 4'hE, 7'h19, 1'b1);
        set_slot(1, 4'hD, 7'h30, 1'b0);
        set_slot(2, 4'hB, 7'h24, 1'b1);
        set_slot(3, 4'h7, 7'h79, 1'b1);
        scan_check("tear_new", 0, 15);

        // ---------------- two loads in one frame: last wins ----------------
        scan_check("two_a", 0, 1);
        value = 16'h1111;
        load  = 1'b1;
        scan_check("two_ld1", 2, 2);
        load  = 1'b0;
        scan_check("two_b", 3, 8);
        value = 16'h2222;
        load  = 1'b1;
        scan_check("two_ld2", 9, 9);
        load  = 1'b0;
        scan_check("two_c", 10, 15);
        set_slot(0, 4'hE, 7'h24, 1'b1);
        set_slot(1, 4'hD, 7'h24, 1'b0);
        set_slot(2, 4'hB, 7'h24, 1'b1);
        set_slot(3, 4'h7, 7'h24, 1'b1);
        scan_check("two_new", 0, 15);

        // ---------------- load exactly on the frame boundary ----------------
        scan_check("bnd_a", 0, 14);
        value    = 16'hFFFF;
        dp_in    = 4'b0000;
        digit_en = 4'hF;
        load     = 1'b1;
        scan_check("bnd_ld", 15, 15);
        load     = 1'b0;
        set_slot(0, 4'hE, 7'h0E, 1'b1);
        set_slot(1, 4'hD, 7'h0E, 1'b1);
        set_slot(2, 4'hB, 7'h0E, 1'b1);
        set_slot(3, 4'h7, 7'h0E, 1'b1);
        scan_check("bnd_f", 0, 14);
        digit_en = 4'b0101;
        load     = 1'b1;
        scan_check("bnd_ld2", 15, 15);
        load     = 1'b0;
        set_slot(1, 4'hF, 7'h7F, 1'b1);
        set_slot(3, 4'hF, 7'h7F, 1'b1);
        scan_check("bnd_en", 0, 15);

        // ---------------- reset in the middle of slot 2 ----------------
        scan_check("mid_pre", 0, 9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an", 16'(an), 16'hF);
        chk("mid_rst_seg", 16'(seg), 16'h7F);
        chk("mid_rst_dp", 16'(dp), 16'h1);
        chk("mid_rst_fd", 16'(frame_done), 16'h0);
        tick();
        tick();
        value    = 16'hFFFF;
        digit_en = 4'hF;
        load     = 1'b1;
        rst_n    = 1'b1;
        first_fd = 0;
        first_an = 4'hF;
        for (int k = 1; k <= 24; k++) begin
            tick();
            load = 1'b0;
            if (frame_done && first_fd == 0) first_fd = k;
            if (an != 4'hF && first_an == 4'hF) first_an = an;
        end
        chk("mid_fd_at", 16'(first_fd), 16'd16);
        chk("mid_first_lit", 16'(first_an), 16'hE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
